// File: rtl/e1_rx_bd_ctrl_if.sv
// Bundle of software-side FIFO/control signals and RX BD handshake for e1_rx_bd_ctrl.
interface e1_rx_bd_ctrl_if #(
  parameter int MFW        = 7,
  parameter int DEPTH_LOG2 = 2,
  parameter int MISS_W     = 16
);
  logic [MFW-1:0]        free_mf;
  logic                  free_push;
  logic                  free_full;
  logic [DEPTH_LOG2:0]   free_level;
  logic [MFW-1:0]        done_mf;
  logic [1:0]            done_crc_e;
  logic                  done_valid;
  logic                  done_ack;
  logic [DEPTH_LOG2:0]   done_level;
  logic [MFW-1:0]        rx_bd_mf;
  logic                  rx_bd_valid;
  logic [1:0]            rx_bd_crc_e;
  logic                  rx_bd_done;
  logic                  rx_bd_miss;
  logic                  ctrl_enable;
  logic                  ctrl_flush;
  logic                  ctrl_clr_err;
  logic [MISS_W-1:0]     miss_cnt;
  logic                  done_ovf;

  modport slave (
    input  free_mf, free_push, done_ack, rx_bd_crc_e, rx_bd_done, rx_bd_miss,
           ctrl_enable, ctrl_flush, ctrl_clr_err,
    output free_full, free_level, done_mf, done_crc_e, done_valid, done_level,
           rx_bd_mf, rx_bd_valid, miss_cnt, done_ovf
  );

  modport master (
    output free_mf, free_push, done_ack, rx_bd_crc_e, rx_bd_done, rx_bd_miss,
           ctrl_enable, ctrl_flush, ctrl_clr_err,
    input  free_full, free_level, done_mf, done_crc_e, done_valid, done_level,
           rx_bd_mf, rx_bd_valid, miss_cnt, done_ovf
  );
endinterface

// File: rtl/e1_rx_bd_ctrl.sv
// E1 RX buffer-descriptor sequencer: free FIFO -> current BD -> done FIFO,
// with saturating miss counter and sticky done-FIFO overflow flag.
module e1_rx_bd_ctrl #(
  parameter int MFW        = 7,
  parameter int DEPTH_LOG2 = 2,
  parameter int MISS_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  e1_rx_bd_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  localparam lvl_t LVL_FULL = lvl_t'(DEPTH);

  logic [MFW-1:0] free_mem [DEPTH];
  logic [MFW+1:0] done_mem [DEPTH];

  ptr_t              free_wr_q, free_rd_q, done_wr_q, done_rd_q;
  lvl_t              free_lvl_q, done_lvl_q;
  state_t            state_q;
  logic              bd_valid_q;
  logic [MFW-1:0]    bd_mf_q;
  logic [MISS_W-1:0] miss_cnt_q;
  logic              done_ovf_q;
  logic [MFW+1:0]    done_head;

  logic free_push_ok, free_pop, done_req, done_pop, done_push_ok, ovf_evt;

  always_comb begin
    free_push_ok = bus.free_push && !bus.ctrl_flush && (free_lvl_q != LVL_FULL);
    free_pop     = (state_q == ST_IDLE) && bus.ctrl_enable && !bus.ctrl_flush
                   && (free_lvl_q != '0);
    done_pop     = bus.done_ack && !bus.ctrl_flush && (done_lvl_q != '0);
    done_req     = (state_q == ST_ACTIVE) && bus.rx_bd_done && !bus.ctrl_flush;
    // A same-cycle pop frees the head slot, so a full done FIFO can still accept.
    done_push_ok = done_req && ((done_lvl_q != LVL_FULL) || done_pop);
    ovf_evt      = done_req && !done_push_ok;
  end

  always_ff @(posedge clk) begin
    if (free_push_ok) free_mem[free_wr_q] <= bus.free_mf;
    if (done_push_ok) done_mem[done_wr_q] <= {bus.rx_bd_crc_e, bd_mf_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_wr_q  <= '0;
      free_rd_q  <= '0;
      free_lvl_q <= '0;
      done_wr_q  <= '0;
      done_rd_q  <= '0;
      done_lvl_q <= '0;
    end else if (bus.ctrl_flush) begin
      free_wr_q  <= '0;
      free_rd_q  <= '0;
      free_lvl_q <= '0;
      done_wr_q  <= '0;
      done_rd_q  <= '0;
      done_lvl_q <= '0;
    end else begin
      if (free_push_ok) free_wr_q <= free_wr_q + ptr_t'(1);
      if (free_pop)     free_rd_q <= free_rd_q + ptr_t'(1);
      if (done_push_ok) done_wr_q <= done_wr_q + ptr_t'(1);
      if (done_pop)     done_rd_q <= done_rd_q + ptr_t'(1);
      free_lvl_q <= free_lvl_q + lvl_t'(free_push_ok) - lvl_t'(free_pop);
      done_lvl_q <= done_lvl_q + lvl_t'(done_push_ok) - lvl_t'(done_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bd_valid_q <= 1'b0;
      bd_mf_q    <= '0;
    end else if (bus.ctrl_flush) begin
      state_q    <= ST_IDLE;
      bd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (free_pop) begin
            state_q    <= ST_ACTIVE;
            bd_valid_q <= 1'b1;
            bd_mf_q    <= free_mem[free_rd_q];
          end
        end
        ST_ACTIVE: begin
          if (bus.rx_bd_done) begin
            state_q    <= ST_IDLE;
            bd_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          bd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over history but not over an event in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
      done_ovf_q <= 1'b0;
    end else begin
      if (bus.ctrl_clr_err) begin
        miss_cnt_q <= MISS_W'(bus.rx_bd_miss);
        done_ovf_q <= ovf_evt;
      end else begin
        if (bus.rx_bd_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + MISS_W'(1);
        if (ovf_evt) done_ovf_q <= 1'b1;
      end
    end
  end

  assign done_head       = done_mem[done_rd_q];
  assign bus.done_mf     = done_head[MFW-1:0];
  assign bus.done_crc_e  = done_head[MFW+1:MFW];
  assign bus.done_valid  = (done_lvl_q != '0);
  assign bus.done_level  = done_lvl_q;
  assign bus.free_level  = free_lvl_q;
  assign bus.free_full   = (free_lvl_q == LVL_FULL);
  assign bus.rx_bd_mf    = bd_mf_q;
  assign bus.rx_bd_valid = bd_valid_q;
  assign bus.miss_cnt    = miss_cnt_q;
  assign bus.done_ovf    = done_ovf_q;
endmodule

// File: doc/e1_rx_bd_ctrl.md
Name: e1_rx_bd_ctrl

Overview:
Buffer-descriptor sequencer for the E1 RX path. Software queues free multiframe buffer indices into a free FIFO. The block hands one index at a time to the RX BD interface (bd_mf/bd_valid) and collects each completed multiframe, with its two sub-multiframe CRC status bits, into a done FIFO for software. It also counts BD misses and flags done-FIFO overflow.

Parameters:
MFW, 7, width of multiframe buffer index (matches RX buf_mf/bd_mf)
DEPTH_LOG2, 2, log2 of each FIFO depth (free and done FIFOs, 4 entries default)
MISS_W, 16, width of saturating miss counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
free_mf  in  MFW  buffer index to queue
free_push  in  1  push free_mf into free FIFO
free_full  out  1  free FIFO full
free_level  out  DEPTH_LOG2+1  free FIFO occupancy
done_mf  out  MFW  head-of-done-FIFO buffer index
done_crc_e  out  2  head CRC status ({smf1_ok, smf0_ok}, 1 = no error)
done_valid  out  1  done FIFO non-empty
done_ack  in  1  pop done FIFO head
done_level  out  DEPTH_LOG2+1  done FIFO occupancy
rx_bd_mf  out  MFW  to RX bd_mf
rx_bd_valid  out  1  to RX bd_valid
rx_bd_crc_e  in  2  from RX bd_crc_e
rx_bd_done  in  1  from RX bd_done (1-cycle pulse)
rx_bd_miss  in  1  from RX bd_miss (1-cycle pulse)
ctrl_enable  in  1  allow loading new BDs
ctrl_flush  in  1  pulse: empty both FIFOs, drop current BD
ctrl_clr_err  in  1  pulse: clear miss_cnt and done_ovf
miss_cnt  out  MISS_W  saturating count of rx_bd_miss pulses
done_ovf  out  1  sticky: a completion was lost due to full done FIFO

Behaviour:
- Reset (rst_n low, async): both FIFOs empty, free_full=0, free_level=0, done_valid=0, done_level=0, rx_bd_valid=0, rx_bd_mf=0, miss_cnt=0, done_ovf=0. done_mf/done_crc_e are don't-care while done_valid=0.
- Current-BD state: two states, IDLE (rx_bd_valid=0) and ACTIVE (rx_bd_valid=1). rx_bd_valid and rx_bd_mf are registered outputs.
- IDLE->ACTIVE: when ctrl_enable=1, free FIFO non-empty and no flush, the block pops the free head into rx_bd_mf. rx_bd_valid=1 on the next edge (1-cycle latency). rx_bd_mf is stable for the whole ACTIVE period.
- ACTIVE->IDLE: only on rx_bd_done or ctrl_flush. ctrl_enable=0 never drops an active BD; it only blocks new loads. Loss of alignment does not drop the BD; it is reused for the next multiframe.
- On rx_bd_done in ACTIVE, the block captures {rx_bd_crc_e, rx_bd_mf} in the same cycle. rx_bd_crc_e is still valid in the done cycle and resets afterwards.
  - Done FIFO not full, or done_ack in the same cycle: push the entry.
  - Otherwise: drop the entry and set done_ovf.
  - rx_bd_valid=0 next cycle. A reload can occur at the earliest on the cycle after that, so rx_bd_valid shows at least one low cycle between BDs.
- rx_bd_done while IDLE: ignored.
- rx_bd_miss: miss_cnt += 1, saturating at all-ones.
- Free FIFO push: accepted iff occupancy < 2^DEPTH_LOG2 at the start of the cycle. A push when full is silently dropped; a simultaneous internal pop does not make room.
  - free_full = (free_level == 2^DEPTH_LOG2).
- Done FIFO pop: done_ack with done_valid=0 is ignored. Simultaneous push and pop leave done_level unchanged, and ordering is preserved.
- Levels: free_level and done_level are registered and exact, range 0..2^DEPTH_LOG2.
- ctrl_flush has highest priority:
  - next cycle, both FIFOs are empty and rx_bd_valid=0;
  - a same-cycle rx_bd_done, free_push or done_ack is discarded;
  - miss_cnt and done_ovf are unaffected.
- ctrl_clr_err: next cycle miss_cnt=0 and done_ovf=0. A same-cycle miss or overflow event takes effect, so the result is miss_cnt=1 or done_ovf=1.
- FIFOs: pointer-based RAM with wrap-around at 2^DEPTH_LOG2, not shift registers. No combinational path from any input to any output except done_mf/done_crc_e, which are read from the head pointer.

Test Plan:
- Basic flow: enable=1, push mf 5 -> rx_bd_valid=1, rx_bd_mf=5 two edges after push. Pulse rx_bd_done with crc_e=2'b10 -> done_valid=1, done_mf=5, done_crc_e=2'b10. rx_bd_valid low next cycle.
- Queue chaining: push 1,2,3; complete three BDs -> rx_bd_mf sequence 1,2,3, each separated by at least 1 cycle with rx_bd_valid=0. Done FIFO order 1,2,3. free_level goes 3→2→1→0.
- Full conditions: push 5 entries with DEPTH_LOG2=2 and enable=0 -> free_level=4, free_full=1, 5th push dropped. Complete 5 BDs without done_ack -> done_level=4, done_ovf=1. ctrl_clr_err -> done_ovf=0.
- Disable mid-MF: ACTIVE on mf 7, drop ctrl_enable -> rx_bd_valid stays 1 until rx_bd_done, then stays 0 despite a non-empty free FIFO.
- Miss counting: 3 rx_bd_miss pulses -> miss_cnt=3. Preload miss_cnt to all-ones-1 with 3 more pulses -> saturates at all-ones. Clear coinciding with a miss -> miss_cnt=1.
- Flush/reset: ACTIVE, 2 free and 2 done entries, ctrl_flush coincident with rx_bd_done -> next cycle all levels 0, rx_bd_valid=0, no new done entry. Assert rst_n low asynchronously mid-ACTIVE -> outputs reach reset values without a clock edge.
